// File: rtl/output_collector_if.sv
// Bus bundle for the output collector: skewed column results in from the array,
// host read port out. The collector uses the slave view, the producer/host the master view.
interface output_collector_if #(
    parameter int outputSize    = 17,
    parameter int numOutChannel = 3,
    parameter int numRegister   = 256
);
    localparam int numAddrBuffer = $clog2(numRegister);

    logic [outputSize-1:0]    matrix_in [numOutChannel];
    logic                     in_valid;
    logic                     rd_en;
    logic [numAddrBuffer-1:0] rd_addr;
    logic [outputSize-1:0]    rd_data [numOutChannel];
    logic                     rd_valid;

    modport master (
        output matrix_in, in_valid, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  matrix_in, in_valid, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/output_collector.sv
// Receive end of the systolic result path: deskews column results, stores each aligned
// vector in an output buffer for a run of cfg_num_outputs vectors, and serves host reads.
module output_collector #(
    parameter int outputSize    = 17,
    parameter int numOutChannel = 3,
    parameter int numRegister   = 256
) (
    input  logic                clk,
    input  logic                nrst,
    output_collector_if.slave   bus,
    input  logic [15:0]         cfg_num_outputs,
    input  logic                ctrl_start,
    output logic [15:0]         out_count,
    output logic                flag_done,
    output logic                flag_overflow
);
    localparam int numAddrBuffer = $clog2(numRegister);
    localparam int vecWidth      = outputSize * numOutChannel;
    localparam int skewDepth     = numOutChannel - 1;
    localparam logic [numAddrBuffer:0] bufDepth = (numAddrBuffer + 1)'(numRegister);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                   state;
    logic [15:0]              cfg_q;
    logic [numAddrBuffer:0]   wr_ptr;
    logic [skewDepth-1:0]     valid_pipe;
    logic [vecWidth-1:0]      aligned;
    logic [vecWidth-1:0]      mem [numRegister];
    logic [vecWidth-1:0]      rd_data_q;
    logic                     rd_valid_q;
    logic                     aligned_valid;
    logic                     wr_accept;
    logic                     mem_we;

    // Column j is delayed by (numOutChannel-1-j) stages so every column lines up with
    // the last one, which is used straight from the input.
    genvar j;
    generate
        for (j = 0; j < numOutChannel - 1; j++) begin : g_skew
            localparam int depth = numOutChannel - 1 - j;
            logic [outputSize-1:0] stage [depth];

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    for (int k = 0; k < depth; k++) stage[k] <= '0;
                end else begin
                    stage[0] <= bus.matrix_in[j];
                    for (int k = 1; k < depth; k++) stage[k] <= stage[k-1];
                end
            end

            assign aligned[j*outputSize +: outputSize] = stage[depth-1];
        end

        for (j = 0; j < numOutChannel; j++) begin : g_rd
            assign bus.rd_data[j] = rd_data_q[j*outputSize +: outputSize];
        end
    endgenerate

    assign aligned[(numOutChannel-1)*outputSize +: outputSize] = bus.matrix_in[numOutChannel-1];

    assign aligned_valid = valid_pipe[skewDepth-1];
    assign wr_accept     = (state == COLLECT) && aligned_valid && !ctrl_start;
    assign mem_we        = wr_accept && (wr_ptr < bufDepth);
    assign bus.rd_valid  = rd_valid_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[numAddrBuffer-1:0]] <= aligned;
    end

    // Read-first: a same-cycle write to the read address is seen on the following read.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= mem[bus.rd_addr];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            cfg_q         <= '0;
            wr_ptr        <= '0;
            out_count     <= '0;
            flag_done     <= 1'b0;
            flag_overflow <= 1'b0;
            valid_pipe    <= '0;
        end else begin
            flag_done     <= 1'b0;
            valid_pipe[0] <= bus.in_valid && (state == COLLECT);
            for (int k = 1; k < skewDepth; k++) valid_pipe[k] <= valid_pipe[k-1];

            if (ctrl_start) begin
                cfg_q         <= cfg_num_outputs;
                wr_ptr        <= '0;
                out_count     <= '0;
                flag_overflow <= 1'b0;
                valid_pipe    <= '0;
                state         <= COLLECT;
            end else begin
                case (state)
                    IDLE: ;
                    COLLECT: begin
                        if (wr_accept) begin
                            out_count <= out_count + 16'd1;
                            if (mem_we) wr_ptr <= wr_ptr + 1'b1;
                            else        flag_overflow <= 1'b1;
                        end
                        if ((cfg_q == 16'd0) || (wr_accept && (out_count + 16'd1 == cfg_q))) begin
                            state     <= DONE;
                            flag_done <= 1'b1;
                        end
                    end
                    DONE: begin
                        valid_pipe <= '0;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_output_collector.sv
// Randomized directed bench for output_collector, checked against a run-level model
// (vector issue cycles, write due times, per-address contents).
module tb_output_collector;
    localparam int W  = 17;
    localparam int N  = 3;
    localparam int R  = 4;
    localparam int AW = $clog2(R);
    localparam int VW = W * N;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [15:0] cfg_num_outputs = '0;
    logic        ctrl_start = 1'b0;
    logic [15:0] out_count;
    logic        flag_done;
    logic        flag_overflow;

    output_collector_if #(.outputSize(W), .numOutChannel(N), .numRegister(R)) bus();

    output_collector #(.outputSize(W), .numOutChannel(N), .numRegister(R)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .bus             (bus),
        .cfg_num_outputs (cfg_num_outputs),
        .ctrl_start      (ctrl_start),
        .out_count       (out_count),
        .flag_done       (flag_done),
        .flag_overflow   (flag_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             due;
        int             addr;
        logic [VW-1:0]  data;
        bit             drop;
    } wr_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    wr_t           pend [$];
    logic [VW-1:0] mem_m [R];
    bit            known [R];
    logic [W-1:0]  sched_d [64][N];
    bit            sched_v [64][N];
    bit            run_m = 0;
    int            k_m = 0;
    int            cfg_m = 0;
    int            cnt_m = 0;
    bit            ovf_m = 0;
    int            done_cyc = -1;
    logic [VW-1:0] last_rd = '0;
    bit            last_known = 1;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack_rd();
        logic [VW-1:0] r;
        for (int j = 0; j < N; j++) r[j*W +: W] = bus.rd_data[j];
        return r;
    endfunction

    // One clock cycle: drive inputs, book the expected effects, step, then compare.
    task automatic apply_stimulus(input bit start, input int cfg, input bit vin,
                                  input logic [VW-1:0] vec, input bit ren, input int raddr);
        logic [VW-1:0] exp_rd;
        bit            exp_known;
        int            slot;
        if (vin) begin
            for (int j = 0; j < N; j++) begin
                sched_d[(cyc + j) % 64][j] = vec[j*W +: W];
                sched_v[(cyc + j) % 64][j] = 1'b1;
            end
        end
        slot = cyc % 64;
        for (int j = 0; j < N; j++) begin
            bus.matrix_in[j] = sched_v[slot][j] ? sched_d[slot][j] : W'($urandom);
            sched_v[slot][j] = 1'b0;
        end
        bus.in_valid    = vin;
        ctrl_start      = start;
        cfg_num_outputs = 16'(cfg);
        bus.rd_en       = ren;
        bus.rd_addr     = AW'(raddr);
        exp_rd    = last_rd;
        exp_known = last_known;
        if (ren) begin
            exp_rd    = mem_m[raddr];
            exp_known = known[raddr];
        end
        if (start) begin
            pend.delete();
            k_m = 0; cfg_m = cfg; cnt_m = 0; ovf_m = 0; run_m = 1;
            done_cyc = (cfg == 0) ? cyc + 2 : -1;
        end else if (vin && run_m && k_m < cfg_m) begin
            pend.push_back('{cyc + N - 1, k_m, vec, k_m >= R});
            if (k_m == cfg_m - 1) done_cyc = cyc + N;
            k_m++;
        end
        @(posedge clk);
        #1;
        cyc++;
        while (pend.size() > 0 && pend[0].due <= cyc - 1) begin
            cnt_m++;
            if (pend[0].drop) ovf_m = 1;
            else begin
                mem_m[pend[0].addr] = pend[0].data;
                known[pend[0].addr] = 1;
            end
            void'(pend.pop_front());
        end
        if (cyc == done_cyc) run_m = 0;
        check_output("rd_valid", 64'(bus.rd_valid), 64'(ren));
        if (exp_known) check_output(ren ? "rd_data" : "rd_hold", 64'(pack_rd()), 64'(exp_rd));
        last_rd    = exp_rd;
        last_known = exp_known;
        check_output("out_count", 64'(out_count), 64'(cnt_m));
        check_output("flag_done", 64'(flag_done), 64'(cyc == done_cyc));
        check_output("flag_overflow", 64'(flag_overflow), 64'(ovf_m));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, '0, 0, 0);
    endtask

    task automatic stream_body(input int nvec, input int prob);
        int issued = 0;
        int budget = 0;
        bit vin;
        while (!(done_cyc >= 0 && cyc > done_cyc + 1) && budget < 300) begin
            vin = (issued < nvec) && ($urandom_range(99) < prob);
            apply_stimulus(0, 0, vin, VW'({$urandom, $urandom}), 1'($urandom_range(1)),
                           int'($urandom_range(R - 1)));
            if (vin) issued++;
            budget++;
        end
        check_output("run_completes", 64'(budget < 300), 64'd1);
    endtask

    task automatic run_stream(input int cfg, input int nvec, input int prob);
        apply_stimulus(1, cfg, 0, '0, 0, 0);
        stream_body(nvec, prob);
    endtask

    task automatic read_back(input int n);
        for (int a = 0; a < n && a < R; a++) apply_stimulus(0, 0, 0, '0, 1, a);
    endtask

    task automatic reset_mid();
        #2 nrst = 1'b0;
        #1;
        check_output("rst_out_count", 64'(out_count), 64'd0);
        check_output("rst_flag_done", 64'(flag_done), 64'd0);
        check_output("rst_flag_overflow", 64'(flag_overflow), 64'd0);
        check_output("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check_output("rst_rd_data", 64'(pack_rd()), 64'd0);
        pend.delete();
        run_m = 0; k_m = 0; cfg_m = 0; cnt_m = 0; ovf_m = 0; done_cyc = -1;
        for (int a = 0; a < R; a++) known[a] = 0;
        last_rd = '0; last_known = 1;
        bus.in_valid = 1'b1; ctrl_start = 1'b0; bus.rd_en = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        nrst = 1'b1;
    endtask

    initial begin
        logic [VW-1:0] vec57;
        logic [VW-1:0] r_old;
        for (int j = 0; j < N; j++) bus.matrix_in[j] = '0;
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        for (int a = 0; a < R; a++) known[a] = 0;
        for (int s = 0; s < 64; s++) for (int j = 0; j < N; j++) sched_v[s][j] = 0;

        $display("[TB] reset state");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("init_out_count", 64'(out_count), 64'd0);
        check_output("init_flag_done", 64'(flag_done), 64'd0);
        check_output("init_flag_overflow", 64'(flag_overflow), 64'd0);
        check_output("init_rd_valid", 64'(bus.rd_valid), 64'd0);
        check_output("init_rd_data", 64'(pack_rd()), 64'd0);
        nrst = 1'b1;

        $display("[TB] deskew of a single vector");
        vec57 = {17'd7, 17'd6, 17'd5};
        apply_stimulus(1, 1, 0, '0, 0, 0);
        idle(1);
        apply_stimulus(0, 0, 1, vec57, 0, 0);
        idle(1);
        check_output("deskew_count_before", 64'(out_count), 64'd0);
        check_output("deskew_done_early", 64'(flag_done), 64'd0);
        idle(1);
        check_output("deskew_count", 64'(out_count), 64'd1);
        check_output("deskew_done", 64'(flag_done), 64'd1);
        idle(1);
        check_output("deskew_done_once", 64'(flag_done), 64'd0);
        apply_stimulus(0, 0, 0, '0, 1, 0);
        check_output("deskew_data", 64'(pack_rd()), 64'(vec57));

        $display("[TB] back-to-back streaming");
        run_stream(4, 4, 100);
        read_back(4);

        $display("[TB] zero-length run");
        run_stream(0, 0, 0);

        $display("[TB] overflow with extra in-flight vectors");
        run_stream(6, 8, 70);
        check_output("ovf_flag", 64'(flag_overflow), 64'd1);
        check_output("ovf_count", 64'(out_count), 64'd6);
        read_back(6);

        $display("[TB] restart with a vector in flight");
        apply_stimulus(1, 3, 0, '0, 0, 0);
        apply_stimulus(0, 0, 1, VW'({$urandom, $urandom}), 0, 0);
        idle(1);
        apply_stimulus(0, 0, 1, VW'({$urandom, $urandom}), 0, 0);
        check_output("restart_one_written", 64'(out_count), 64'd1);
        apply_stimulus(1, 3, 0, '0, 0, 0);
        check_output("restart_count_clear", 64'(out_count), 64'd0);
        stream_body(3, 100);
        read_back(3);

        $display("[TB] read-first collision on address 2");
        apply_stimulus(1, 3, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, VW'({$urandom, $urandom}), 0, 0);
        apply_stimulus(0, 0, 0, '0, 1, 2);
        r_old = pack_rd();
        apply_stimulus(0, 0, 0, '0, 1, 2);
        check_output("read_first", 64'(pack_rd()), 64'(r_old));
        apply_stimulus(0, 0, 0, '0, 1, 2);
        idle(2);

        $display("[TB] random runs");
        for (int r = 0; r < 3; r++) begin
            int c;
            c = int'($urandom_range(7, 1));
            run_stream(c, c + int'($urandom_range(2)), 60);
            read_back(c);
        end

        $display("[TB] reset during a run");
        apply_stimulus(1, 5, 0, '0, 0, 0);
        apply_stimulus(0, 0, 1, VW'({$urandom, $urandom}), 0, 0);
        apply_stimulus(0, 0, 1, VW'({$urandom, $urandom}), 0, 0);
        reset_mid();
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1, VW'({$urandom, $urandom}), 0, 0);
        run_stream(3, 3, 80);
        read_back(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/output_collector.md
Name: output_collector

Overview:
- Receive end of the systolic array result path. Captures the column-skewed matrix_out vectors from tpu_top, deskews them, and writes each aligned output vector into an output buffer.
- The host reads the buffer back by address, which is the mirror of buffer_router's host write port.
- Sits beside buffer_router inside the TPU system, between tpu_top and the host.

Parameters:
- outputSize, 17, bit width of one PE column result (dataSize*2 + clog2(numInChannel) + 1).
- numOutChannel, 3, number of PE columns (nPEx), i.e. results per output vector.
- numRegister, 256, depth of the output buffer in vectors.
- numAddrBuffer, clog2(numRegister), localparam, address width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- nrst  input  1  asynchronous active-low reset.
- matrix_in  input  [outputSize-1:0] x numOutChannel (unpacked array)  column results from tpu_top; column j carries its element j cycles after column 0.
- in_valid  input  1  column-0 element of a new output vector is on matrix_in[0] this cycle.
- cfg_num_outputs  input  16  number of vectors to collect per run. Sampled on ctrl_start.
- ctrl_start  input  1  single-cycle pulse that begins a collection run.
- rd_en  input  1  host read request.
- rd_addr  input  numAddrBuffer  vector index to read.
- rd_data  output  [outputSize-1:0] x numOutChannel  read vector, registered.
- rd_valid  output  1  rd_data is valid this cycle.
- out_count  output  16  vectors written in the current run.
- flag_done  output  1  one-cycle pulse when the run completes.
- flag_overflow  output  1  sticky; a write was dropped because the buffer was full.

Behaviour:
- Reset: every output, counters, write pointer, skew pipelines and stored cfg are cleared to 0, and the FSM goes to IDLE. Buffer contents are undefined after reset. Reset mid-run aborts the run with no done pulse.
- Deskew:
  - Column j passes through (numOutChannel-1-j) registers; the last column is combinational.
  - in_valid rides a numOutChannel-1 stage valid shift register.
  - in_valid at cycle t writes the full vector {col0@t, col1@t+1, ..., colN-1@t+N-1} at the clock edge ending cycle t+N-1. Latency is N-1 cycles.
  - Back-to-back in_valid on every cycle is supported, giving one write per cycle.
- FSM states IDLE, COLLECT, DONE:
  - IDLE: in_valid is ignored (not entered into the valid pipe). ctrl_start latches cfg_num_outputs, clears wr_ptr/out_count/flag_overflow and the valid pipe, then goes to COLLECT.
  - COLLECT: in_valid enters the valid pipe. On each aligned write, if wr_ptr < numRegister, the buffer is written at wr_ptr and wr_ptr increments; otherwise the write is dropped and flag_overflow is set. out_count increments on every aligned write, including dropped ones.
  - COLLECT to DONE: when out_count reaches cfg_num_outputs (checked after the increment).
  - cfg_num_outputs = 0 goes COLLECT to DONE on the next cycle with no writes.
  - DONE: flag_done = 1 for exactly this cycle. The valid pipe is flushed and the FSM returns to IDLE.
  - ctrl_start in COLLECT or DONE restarts the run exactly as from IDLE. In-flight vectors are discarded and no done pulse is issued for the aborted run.
  - Extra in_valid after the last counted vector but still in flight is discarded when DONE is entered.
- Read port:
  - rd_en at cycle t gives rd_data/rd_valid at t+1.
  - rd_data holds its value when rd_en = 0; rd_valid = 0 in that case.
  - Reads are allowed in any state.
  - Read and write to the same address in the same cycle return the old data (read-first).
  - rd_addr ≥ numRegister cannot occur because the address width is exact.
- Widths: out_count and cfg are 16-bit. Data is stored unmodified, with no arithmetic or sign change.

Test Plan:
- Deskew: N=3, start with cfg=1. in_valid at t=10 with col0=5 at t10, col1=6 at t11, col2=7 at t12. Expect a write at the t12 edge; a read of addr0 gives {5,6,7}, out_count=1, and flag_done high at t13 only.
- Streaming: cfg=4, in_valid for 4 consecutive cycles with distinct values. Expect addrs 0..3 hold the correct aligned vectors, flag_done pulses once, and the FSM returns to IDLE.
- Overflow: numRegister=4, cfg=6, 6 vectors. Expect addrs 0..3 written, flag_overflow=1 from the 5th aligned write, out_count=6, and flag_done pulses.
- Restart: cfg=3, ctrl_start reasserted after 1 write with 1 vector in flight. Expect out_count=0 and the in-flight vector not written; the new run starts writing at addr0.
- Read timing: rd_en with rd_addr=2 at t → rd_valid=1 and data at t+1. Read and write to addr 2 in the same cycle → old value returned.
- Reset mid-COLLECT: nrst low asynchronously. Expect all outputs 0 immediately, in_valid ignored until the next ctrl_start, and no flag_done.
